fir_result_fifo: RTL and testbench

//  Downstream stage of the shared-multiplier 3-tap FIR (y = x1*r1 + x2*r2 + x3*r3).

---
 rtl/fir_result_fifo.sv | 143 ++++++++++++++
 tb/tb_fir_result_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fir_result_fifo.sv
// fir_result_fifo: output stage of the 3-tap FIR.
// Each full-width result is rounded (half-up), right-shifted and clipped to OUT_W bits.
// The narrowed sample is then queued in a first-word-fall-through FIFO for the consumer.
// Saturation is reported as a one-cycle pulse. A result dropped on a full FIFO sets a sticky flag.
module fir_result_fifo #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic                    y_valid,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_W:0]         count,
  output logic                    sat_flag,
  output logic                    overflow
);

  // One guard bit above the input so the rounding add can never wrap.
  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;
  localparam logic [ADDR_W:0]         FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic signed [EXT_W-1:0] y_ext;
  logic signed [EXT_W-1:0] scaled;
  logic signed [OUT_W-1:0] clipped;
  logic                    clip_hit;

  assign y_ext = $signed({y_in[IN_W-1], y_in});

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1 << (SHIFT - 1));
      assign scaled = (y_ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign scaled = y_ext;
    end
  endgenerate

  // Clip the rescaled value into the signed OUT_W range and note whether it was clipped.
  always_comb begin
    clipped  = scaled[OUT_W-1:0];
    clip_hit = 1'b0;
    if (scaled > MAX_V) begin
      clipped  = MAX_V[OUT_W-1:0];
      clip_hit = 1'b1;
    end else if (scaled < MIN_V) begin
      clipped  = MIN_V[OUT_W-1:0];
      clip_hit = 1'b1;
    end
  end

  // Stage-1 registers, FIFO bookkeeping and flags.
  logic                    s1_valid_q, s1_valid_d;
  logic signed [OUT_W-1:0] s1_data_q, s1_data_d;
  logic                    sat_q, sat_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic signed [OUT_W-1:0] mem_q [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake decode. A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_COUNT);
    pop   = !empty && m_ready;
    push  = s1_valid_q && (!full || pop);
    drop  = s1_valid_q && full && !pop;
  end

  // Next-state for stage 1, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    s1_valid_d = y_valid;
    s1_data_d  = s1_data_q;
    sat_d      = y_valid && clip_hit;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || drop;
    if (y_valid) begin
      s1_data_d = clipped;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  // State register. Reset also discards whatever sits in stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sat_q      <= sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array. No reset is needed because m_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  assign m_valid  = !empty;
  assign m_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign sat_flag = sat_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_result_fifo.sv
// Scoreboard bench for fir_result_fifo.
// Stimulus pushes hand-computed expected samples into a queue.
// A monitor pops and compares that queue on every completed output handshake.
module tb_fir_result_fifo;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [17:0] y_in = '0;
  logic               y_valid = 1'b0;
  logic signed [7:0]  m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [3:0]         count;
  logic               sat_flag;
  logic               overflow;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  fir_result_fifo #(
    .IN_W(18), .OUT_W(8), .SHIFT(2), .DEPTH(8), .ADDR_W(3)
  ) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .sat_flag(sat_flag), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle result strobe; keep=1 means the sample must later appear with value exp.
  task automatic strobe(input int y, input bit keep, input int exp);
    y_in    = 18'(y);
    y_valid = 1'b1;
    if (keep) exp_q.push_back(exp);
    tick();
    y_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 100 && count != 0; i++) tick();
    chk(name, int'(count), 0);
  endtask

  initial begin
    fork
      // Monitor: each accepted output must match the head of the expected queue.
      forever begin
        @(negedge clk);
        if (!rst && m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(m_data), -999);
          end else begin
            chk("m_data", int'(m_data), exp_q.pop_front());
          end
        end
      end
    join_none

    // 1. Reset held while strobes toggle.
    for (int i = 0; i < 4; i++) begin
      y_in    = 18'sd1000;
      y_valid = (i % 2 == 0);
      tick();
    end
    y_valid = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_m_data", int'(m_data), 0);
    tick();
    rst = 1'b0;
    idle(2);

    // 2. Rounding with the consumer always ready, including a latency probe.
    m_ready = 1'b1;
    strobe(6, 1, 2);
    @(negedge clk);
    chk("lat_m_valid_n1", int'(m_valid), 0);
    chk("round_sat_flag", int'(sat_flag), 0);
    @(negedge clk);
    chk("lat_m_valid_n2", int'(m_valid), 1);
    tick();
    strobe(-6, 1, -1);
    strobe(5, 1, 1);
    strobe(-5, 1, -1);
    idle(5);

    // 3. Saturation pulses.
    strobe(1000, 1, 127);
    @(negedge clk);
    chk("sat_pos_flag", int'(sat_flag), 1);
    strobe(-1000, 1, -128);
    @(negedge clk);
    chk("sat_neg_flag", int'(sat_flag), 1);
    strobe(508, 1, 127);
    @(negedge clk);
    chk("no_sat_508_flag", int'(sat_flag), 0);
    idle(5);
    wait_empty("drain_sat");

    // 4. Fill to full with the consumer stalled; the ninth result is dropped.
    m_ready = 1'b0;
    for (int k = 1; k <= 9; k++) strobe(4 * k, k <= 8, k);
    idle(3);
    chk("fill_count", int'(count), 8);
    chk("fill_overflow", int'(overflow), 1);
    chk("fill_head", int'(m_data), 1);
    m_ready = 1'b1;
    wait_empty("drain_fill");
    chk("overflow_sticky", int'(overflow), 1);
    m_ready = 1'b0;

    // Clear the sticky flag before the full push+pop case.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("overflow_cleared", int'(overflow), 0);

    // 5. Full FIFO with simultaneous push and pop.
    for (int k = 1; k <= 8; k++) strobe(4 * k, 1, k);
    idle(2);
    chk("full_count", int'(count), 8);
    strobe(40, 1, 10);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("pushpop_count", int'(count), 8);
    chk("pushpop_overflow", int'(overflow), 0);
    m_ready = 1'b1;
    wait_empty("drain_pushpop");
    m_ready = 1'b0;

    // 6. Reset while a result is in flight in stage 1.
    for (int k = 11; k <= 15; k++) strobe(4 * k, 1, k);
    idle(2);
    chk("mid_count", int'(count), 5);
    strobe(400, 0, 0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_m_valid", int'(m_valid), 0);
    tick();
    rst = 1'b0;
    idle(3);
    chk("inflight_gone", int'(count), 0);
    m_ready = 1'b1;
    strobe(44, 1, 11);
    idle(4);
    wait_empty("drain_after_rst");

    chk("scoreboard_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
